// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch constants, instruction field positions and fetch-state enum
package cpu_pkg;

    localparam int INSTR_W = 32;

    // Register-index fields of the instruction word
    localparam int RS_MSB    = 25;
    localparam int RS_LSB    = 21;
    localparam int RT_MSB    = 20;
    localparam int RT_LSB    = 16;
    localparam int REG_IDX_W = RS_MSB - RS_LSB + 1;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2,
        ST_ERR  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/ifu_pc_reg.sv
// rtl/ifu_pc_reg.sv - fetch PC register, +4 adder and squashed-redirect target latch
module ifu_pc_reg
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_seq,
    input  logic              load_redirect,
    input  logic              load_target,
    input  logic              squash_set,
    input  logic              squash_clr,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic [ADDR_W-1:0] id_pc,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] id_pc_plus4,
    output logic              squash
);

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] target_d;
    logic [ADDR_W-1:0] target_q;
    logic              squash_d;
    logic              squash_q;

    // Sequential successor of the held instruction; wraps modulo 2^ADDR_W
    assign id_pc_plus4 = id_pc + PC_STEP;

    // Next PC: a live redirect beats a pending squash target, which beats sequential flow
    always_comb begin
        pc_d     = pc_q;
        target_d = target_q;
        squash_d = squash_q;
        if (load_redirect) begin
            pc_d = redirect_pc;
        end else if (load_target) begin
            pc_d = target_q;
        end else if (load_seq) begin
            pc_d = id_pc_plus4;
        end
        // A later redirect overwrites the latched target so the last one wins
        if (squash_set) begin
            squash_d = 1'b1;
            target_d = redirect_pc;
        end else if (squash_clr) begin
            squash_d = 1'b0;
        end
    end

    // PC, target and squash state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q     <= RESET_PC;
            target_q <= '0;
            squash_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            target_q <= target_d;
            squash_q <= squash_d;
        end
    end

    assign pc     = pc_q;
    assign squash = squash_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - single-outstanding instruction fetch FSM (IFU_ALIGN_CHECK_EN enables misaligned-redirect trap)
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          ADDR_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 imem_req,
    output logic [ADDR_W-1:0]    imem_addr,
    input  logic                 imem_ack,
    input  logic [INSTR_W-1:0]   imem_rdata,
    input  logic                 redirect,
    input  logic [ADDR_W-1:0]    redirect_pc,
    output logic                 id_valid,
    input  logic                 id_ready,
    output logic [INSTR_W-1:0]   id_instr,
    output logic [ADDR_W-1:0]    id_pc,
    output logic [ADDR_W-1:0]    id_pc_plus4,
    output logic [REG_IDX_W-1:0] id_rs,
    output logic [REG_IDX_W-1:0] id_rt,
    output logic                 fetch_err
);

    fetch_state_e        state_d;
    fetch_state_e        state_q;
    logic [INSTR_W-1:0]  id_instr_d;
    logic [INSTR_W-1:0]  id_instr_q;
    logic [ADDR_W-1:0]   id_pc_d;
    logic [ADDR_W-1:0]   id_pc_q;
    logic [ADDR_W-1:0]   pc;
    logic [ADDR_W-1:0]   redirect_tgt;
    logic                squash;
    logic                redirect_bad;
    logic                load_seq;
    logic                load_redirect;
    logic                load_target;
    logic                squash_set;
    logic                squash_clr;

    // Fetch addresses are always word aligned
    assign redirect_tgt = {redirect_pc[ADDR_W-1:2], 2'b00};

`ifdef IFU_ALIGN_CHECK_EN
    assign redirect_bad = |redirect_pc[1:0];
    assign fetch_err    = (state_q == ST_ERR);
`else
    logic align_bits_unused;
    assign align_bits_unused = ^redirect_pc[1:0];
    assign redirect_bad      = 1'b0;
    assign fetch_err         = 1'b0;
`endif

    ifu_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (ADDR_W'(RESET_PC))
    ) u_pc_reg (
        .clk           (clk),
        .rst           (rst),
        .load_seq      (load_seq),
        .load_redirect (load_redirect),
        .load_target   (load_target),
        .squash_set    (squash_set),
        .squash_clr    (squash_clr),
        .redirect_pc   (redirect_tgt),
        .id_pc         (id_pc_q),
        .pc            (pc),
        .id_pc_plus4   (id_pc_plus4),
        .squash        (squash)
    );

    // Next-state, PC control and decode-register capture
    always_comb begin
        state_d       = state_q;
        id_instr_d    = id_instr_q;
        id_pc_d       = id_pc_q;
        load_seq      = 1'b0;
        load_redirect = 1'b0;
        load_target   = 1'b0;
        squash_set    = 1'b0;
        squash_clr    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Any ack seen here belongs to a request abandoned by reset
                state_d = ST_REQ;
                if (redirect) begin
                    if (redirect_bad) begin
                        state_d = ST_ERR;
                    end else begin
                        load_redirect = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                if (redirect) begin
                    if (redirect_bad) begin
                        state_d    = ST_ERR;
                        squash_clr = 1'b1;
                    end else if (imem_ack) begin
                        // Response arrived with the redirect: drop it, refetch at target
                        load_redirect = 1'b1;
                        squash_clr    = 1'b1;
                    end else begin
                        // Keep the outstanding request alive; its response gets dropped
                        squash_set = 1'b1;
                    end
                end else if (imem_ack) begin
                    if (squash) begin
                        load_target = 1'b1;
                        squash_clr  = 1'b1;
                    end else begin
                        id_instr_d = imem_rdata;
                        id_pc_d    = pc;
                        state_d    = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                // Redirect wins over a same-cycle handshake: the held word is dropped
                if (redirect) begin
                    if (redirect_bad) begin
                        state_d = ST_ERR;
                    end else begin
                        load_redirect = 1'b1;
                        state_d       = ST_REQ;
                    end
                end else if (id_ready) begin
                    load_seq = 1'b1;
                    state_d  = ST_REQ;
                end
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state and decode-stage holding registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            id_instr_q <= '0;
            id_pc_q    <= '0;
        end else begin
            state_q    <= state_d;
            id_instr_q <= id_instr_d;
            id_pc_q    <= id_pc_d;
        end
    end

    assign imem_req  = (state_q == ST_REQ);
    assign imem_addr = pc;
    assign id_valid  = (state_q == ST_HOLD);
    assign id_instr  = id_instr_q;
    assign id_pc     = id_pc_q;
    assign id_rs     = id_instr_q[RS_MSB:RS_LSB];
    assign id_rt     = id_instr_q[RT_MSB:RT_LSB];

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter ADDR_W, default 32, meaning the PC and memory address width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low (0 = reset).
REQ-005 SHALL have port imem_req, output, 1 bit: instruction memory request.
REQ-006 SHALL have port imem_addr, output, ADDR_W bits: fetch address, word aligned.
REQ-007 SHALL have port imem_ack, input, 1 bit: memory response valid; it may arrive in the same cycle as imem_req.
REQ-008 SHALL have port imem_rdata, input, 32 bits: instruction word, sampled when imem_ack=1.
REQ-009 SHALL have port redirect, input, 1 bit: branch/jump taken.
REQ-010 SHALL have port redirect_pc, input, ADDR_W bits: the new PC.
REQ-011 SHALL have port id_valid, output, 1 bit: the instruction is held for decode.
REQ-012 SHALL have port id_ready, input, 1 bit: decode/register-file stage accepts.
REQ-013 SHALL have port id_instr, output, 32 bits: the held instruction.
REQ-014 SHALL have port id_pc, output, ADDR_W bits: the held instruction's PC.
REQ-015 SHALL have port id_pc_plus4, output, ADDR_W bits: id_pc+4.
REQ-016 SHALL have port id_rs, output, 5 bits: id_instr[25:21], feeding the RegisterFile readReg1.
REQ-017 SHALL have port id_rt, output, 5 bits: id_instr[20:16], feeding the RegisterFile readReg2.
REQ-018 SHALL have port fetch_err, output, 1 bit: sticky misaligned-redirect error.

Function
REQ-019 SHALL implement FSM states IDLE, REQ, HOLD, ERR.
REQ-020 IDLE SHALL last exactly one cycle after reset release, then go to REQ.
REQ-021 REQ: imem_req=1, with imem_addr=pc held stable until imem_ack.
REQ-022 REQ with imem_ack and no squash: SHALL capture imem_rdata and pc into id_* and go to HOLD; id_valid=1 from the next cycle.
REQ-023 HOLD: id_valid=1 and id_* stable until id_valid&&id_ready.
REQ-024 On handshake: pc<=id_pc+4 and go to REQ; throughput is 1 instruction per 2 cycles with a zero-wait memory.
REQ-025 Only one request SHALL be outstanding at any time.
REQ-026 redirect in REQ without ack: SHALL set a squash flag and latch redirect_pc; imem_addr stays unchanged; the next ack SHALL be discarded; then REQ at the latched target.
REQ-027 redirect in the same cycle as imem_ack: SHALL discard the data; the next cycle SHALL be REQ at redirect_pc.
REQ-028 redirect in HOLD: id_valid=0 next cycle and the instruction is dropped even if id_ready=1 that cycle; then REQ at redirect_pc.
REQ-029 Multiple redirects before an ack: the last one wins.
REQ-030 PC arithmetic: modulo 2^ADDR_W; 32'hFFFF_FFFC+4 -> 32'h0000_0000.

Reset
REQ-031 On rst=0, asynchronously: state=IDLE, pc=RESET_PC, squash=0, imem_req=0, id_valid=0, id_instr=0, id_pc=0, fetch_err=0.
REQ-032 Reset mid-request SHALL abandon the request; an ack arriving while in IDLE SHALL be ignored.

Configuration
REQ-033 The macro IFU_ALIGN_CHECK_EN SHALL control alignment checking.
REQ-034 With IFU_ALIGN_CHECK_EN defined: redirect_pc[1:0]!=0 SHALL move to ERR; ERR keeps imem_req=0 and id_valid=0 with fetch_err=1 until reset.
REQ-035 Without IFU_ALIGN_CHECK_EN: redirect_pc[1:0] SHALL be forced to 2'b00, ERR SHALL be unreachable, and fetch_err SHALL be tied 0; the port exists in both builds.

Structure
REQ-036 Shared package cpu_pkg SHALL hold: INSTR_W=32, RS/RT field bit positions, the fetch-state enum, and the default RESET_PC.
REQ-037 One sub-module, ifu_pc_reg, SHALL own the PC register, the +4 adder and the redirect/squash target latch; the FSM stays in instr_fetch_unit.

Verification
REQ-038 Reset release, ack the same cycle as req, id_ready=1: imem_addr sequence 0,4,8; each id_valid pulse carries the matching id_pc; id_rs/id_rt equal the rdata fields.
REQ-039 rdata=32'h012A_4020 with id_ready=0 for 5 cycles: id_instr is stable, id_rs=9, id_rt=10; after id_ready=1 the next imem_addr is pc+4.
REQ-040 Ack delayed 3 cycles, redirect to 32'h100 in cycle 1: the stale ack is discarded, the next imem_addr is 32'h100, and no id_valid is raised for the stale word.
REQ-041 Starting from pc=32'hFFFF_FFFC: id_pc_plus4=0 and the next imem_addr is 0.
REQ-042 Redirect to 32'h102: with IFU_ALIGN_CHECK_EN, fetch_err=1 and imem_req stays 0 until reset; without it, imem_addr=32'h100.
REQ-043 rst=0 asserted while imem_req=1: outputs clear immediately, without a clock edge, and the first post-reset request is at RESET_PC.
